axis_pkt_buffer: RTL and testbench

Parametrised AXI-stream store-and-forward packet buffer: receives one complete packet on a slave stream into internal memory, then replays it on a master stream with its keep mask. Oversized packets are dropped whole and counted. It sits between the MAC-side receive stream and the protocol parsers (IPv4/UDP). It is the generalised successor of the fixed 4×16-bit loopback buffer, with explicit state, overflow handling and header capture.

---
 rtl/axis_pkt_buffer_pkg.sv | 30 +++
 rtl/axis_pkt_buffer_if.sv | 32 +++
 rtl/axis_pkt_mem.sv | 33 +++
 rtl/axis_pkt_buffer.sv | 243 ++++++++++++++++++++++++
 tb/tb_axis_pkt_buffer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/axis_pkt_buffer_pkg.sv
// -----------------------------------------------------------------------------
// axis_pkt_pkg
// Shared types and constants for the AXI-stream store-and-forward packet
// buffer (axis_pkt_buffer) and its memory.
//   state_t      : buffer FSM states
//   HDR_*        : beat index of each captured UDP header word
//   sat_inc8     : saturating 8-bit increment used by the drop counter
// Optional feature macro used by the design: AXIS_PKT_BUF_HDR_EN
// -----------------------------------------------------------------------------
package axis_pkt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2,
        SEND = 2'd3
    } state_t;

    // UDP header word positions within the first four beats of a packet
    localparam int HDR_SRC   = 0;
    localparam int HDR_DST   = 1;
    localparam int HDR_LEN   = 2;
    localparam int HDR_CSUM  = 3;
    localparam int HDR_WORDS = 4;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/axis_pkt_buffer_if.sv
// -----------------------------------------------------------------------------
// axis_pkt_buffer_if
// Minimal AXI-stream bundle: valid/ready handshake plus data, keep, last.
//   master modport : drives valid/data/keep/last, receives ready
//   slave  modport : receives valid/data/keep/last, drives ready
// Parameter DATA_W sets the data width; keep is DATA_W/8 bits.
// -----------------------------------------------------------------------------
interface axis_pkt_buffer_if #(
    parameter int DATA_W = 16
);
    logic                  valid;
    logic                  ready;
    logic [DATA_W-1:0]     data;
    logic [DATA_W/8-1:0]   keep;
    logic                  last;

    modport master (
        output valid,
        output data,
        output keep,
        output last,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  keep,
        input  last,
        output ready
    );
endinterface

// File: rtl/axis_pkt_mem.sv
// -----------------------------------------------------------------------------
// axis_pkt_mem
// DEPTH x WIDTH simple dual-port RAM: synchronous write, asynchronous read.
// Contents are not reset.
//   clk      in  clock
//   wr_en    in  write strobe
//   wr_addr  in  write address
//   wr_data  in  write word
//   rd_addr  in  read address
//   rd_data  out read word (combinational from rd_addr)
// -----------------------------------------------------------------------------
module axis_pkt_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 18,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_reg[rd_addr];
endmodule

// File: rtl/axis_pkt_buffer.sv
// -----------------------------------------------------------------------------
// axis_pkt_buffer
// Store-and-forward AXI-stream packet buffer. A whole packet is written into
// internal memory from the slave stream, then replayed on the master stream
// with its keep mask. Packets longer than DEPTH beats are discarded whole.
//   clk, reset      clock, synchronous active-high reset
//   s (slave)       inbound stream; ready low only while replaying
//   m (master)      outbound stream; payload registered, stable while stalled
//   pkt_count  16   packets fully forwarded (wraps)
//   drop_count  8   packets dropped (saturates at 255)
//   drop        1   one-cycle pulse per dropped packet
//   hdr_src/dst/len/csum, hdr_valid   only when AXIS_PKT_BUF_HDR_EN is
//                   defined: first four beats' s_data[15:0] of each
//                   forwarded packet of >= 4 beats (requires DATA_W >= 16)
// -----------------------------------------------------------------------------
module axis_pkt_buffer
    import axis_pkt_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int KEEP_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    axis_pkt_buffer_if.slave  s,
    axis_pkt_buffer_if.master m,
    output logic [15:0]       pkt_count,
    output logic [7:0]        drop_count,
    output logic              drop
`ifdef AXIS_PKT_BUF_HDR_EN
    ,
    output logic [15:0]       hdr_src,
    output logic [15:0]       hdr_dst,
    output logic [15:0]       hdr_len,
    output logic [15:0]       hdr_csum,
    output logic              hdr_valid
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;           // counts 0..DEPTH inclusive
    localparam int MW = DATA_W + KEEP_W;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    state_t              state_reg;
    logic [CW-1:0]       wr_cnt_reg;
    logic [CW-1:0]       rd_ptr_reg;
    logic [CW-1:0]       len_reg;
    logic                m_valid_reg;
    logic                m_last_reg;
    logic [DATA_W-1:0]   m_data_reg;
    logic [KEEP_W-1:0]   m_keep_reg;
    logic [15:0]         pkt_count_reg;
    logic [7:0]          drop_count_reg;
    logic                drop_reg;

    logic                accept;
    logic                m_fire;
    logic                room;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [AW-1:0]       rd_addr;
    logic [MW-1:0]       wr_word;
    logic [MW-1:0]       rd_word;
    logic [CW-1:0]       rd_next;
    logic [CW-1:0]       wr_cnt_inc;
    logic [CW-1:0]       last_idx;

    assign s.ready    = (state_reg != SEND);
    assign accept     = s.valid && s.ready;
    assign m_fire     = m_valid_reg && m.ready;
    assign room       = (wr_cnt_reg < DEPTH_C);
    assign wr_en      = accept && ((state_reg == IDLE) || ((state_reg == RECV) && room));
    assign wr_addr    = (state_reg == IDLE) ? '0 : wr_cnt_reg[AW-1:0];
    assign wr_word    = {s.keep, s.data};
    assign wr_cnt_inc = wr_cnt_reg + CW'(1);
    assign rd_next    = rd_ptr_reg + CW'(1);
    assign last_idx   = len_reg - CW'(1);
    // While replaying, look one beat ahead so the output register can load
    // the next word on a handshake; otherwise point at beat 0 for SEND entry.
    assign rd_addr    = (state_reg == SEND) ? rd_next[AW-1:0] : '0;

    axis_pkt_mem #(
        .DEPTH (DEPTH),
        .WIDTH (MW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_word),
        .rd_addr (rd_addr),
        .rd_data (rd_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            wr_cnt_reg     <= '0;
            rd_ptr_reg     <= '0;
            len_reg        <= '0;
            m_valid_reg    <= 1'b0;
            m_last_reg     <= 1'b0;
            m_data_reg     <= '0;
            m_keep_reg     <= '0;
            pkt_count_reg  <= '0;
            drop_count_reg <= '0;
            drop_reg       <= 1'b0;
        end else begin
            drop_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        wr_cnt_reg <= CW'(1);
                        if (s.last) begin
                            // Single-beat packet: the word is being written
                            // this cycle, so present it straight from the input.
                            len_reg     <= CW'(1);
                            rd_ptr_reg  <= '0;
                            m_valid_reg <= 1'b1;
                            m_last_reg  <= 1'b1;
                            m_data_reg  <= s.data;
                            m_keep_reg  <= s.keep;
                            state_reg   <= SEND;
                        end else begin
                            state_reg <= RECV;
                        end
                    end
                end
                RECV: begin
                    if (accept) begin
                        if (room) begin
                            wr_cnt_reg <= wr_cnt_inc;
                            if (s.last) begin
                                // Length >= 2 here, so beat 0 is not the last.
                                len_reg     <= wr_cnt_inc;
                                rd_ptr_reg  <= '0;
                                m_valid_reg <= 1'b1;
                                m_last_reg  <= 1'b0;
                                m_data_reg  <= rd_word[DATA_W-1:0];
                                m_keep_reg  <= rd_word[MW-1:DATA_W];
                                state_reg   <= SEND;
                            end
                        end else if (s.last) begin
                            drop_reg       <= 1'b1;
                            drop_count_reg <= sat_inc8(drop_count_reg);
                            state_reg      <= IDLE;
                        end else begin
                            state_reg <= DROP;
                        end
                    end
                end
                DROP: begin
                    if (accept && s.last) begin
                        drop_reg       <= 1'b1;
                        drop_count_reg <= sat_inc8(drop_count_reg);
                        state_reg      <= IDLE;
                    end
                end
                SEND: begin
                    if (m_fire) begin
                        if (m_last_reg) begin
                            m_valid_reg   <= 1'b0;
                            m_last_reg    <= 1'b0;
                            rd_ptr_reg    <= '0;
                            pkt_count_reg <= pkt_count_reg + 16'd1;
                            state_reg     <= IDLE;
                        end else begin
                            rd_ptr_reg <= rd_next;
                            m_data_reg <= rd_word[DATA_W-1:0];
                            m_keep_reg <= rd_word[MW-1:DATA_W];
                            m_last_reg <= (rd_next == last_idx);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign m.valid    = m_valid_reg;
    assign m.last     = m_last_reg;
    assign m.data     = m_data_reg;
    assign m.keep     = m_keep_reg;
    assign pkt_count  = pkt_count_reg;
    assign drop_count = drop_count_reg;
    assign drop       = drop_reg;

`ifdef AXIS_PKT_BUF_HDR_EN
    // Header words are staged as they arrive and only published when the
    // packet is committed to SEND with at least four beats, so dropped or
    // short packets never disturb the visible fields.
    logic [CW-1:0] beat_idx;
    logic [15:0]   hdr_word [HDR_WORDS];
    logic          hdr_commit;
    logic [15:0]   hdr_src_reg;
    logic [15:0]   hdr_dst_reg;
    logic [15:0]   hdr_len_reg;
    logic [15:0]   hdr_csum_reg;
    logic          hdr_valid_reg;

    assign beat_idx   = (state_reg == IDLE) ? '0 : wr_cnt_reg;
    assign hdr_commit = accept && (state_reg == RECV) && room && s.last
                        && (wr_cnt_reg >= CW'(HDR_WORDS - 1));

    generate
        for (genvar gi = 0; gi < HDR_WORDS; gi++) begin : g_hdr
            logic        hit;
            logic [15:0] stage_reg;
            assign hit = wr_en && (beat_idx == CW'(gi));
            always_ff @(posedge clk) begin
                if (hit) begin
                    stage_reg <= s.data[15:0];
                end
            end
            // Bypass covers the case where this word arrives on the last beat.
            assign hdr_word[gi] = hit ? s.data[15:0] : stage_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            hdr_src_reg   <= '0;
            hdr_dst_reg   <= '0;
            hdr_len_reg   <= '0;
            hdr_csum_reg  <= '0;
            hdr_valid_reg <= 1'b0;
        end else begin
            hdr_valid_reg <= hdr_commit;
            if (hdr_commit) begin
                hdr_src_reg  <= hdr_word[HDR_SRC];
                hdr_dst_reg  <= hdr_word[HDR_DST];
                hdr_len_reg  <= hdr_word[HDR_LEN];
                hdr_csum_reg <= hdr_word[HDR_CSUM];
            end
        end
    end

    assign hdr_src   = hdr_src_reg;
    assign hdr_dst   = hdr_dst_reg;
    assign hdr_len   = hdr_len_reg;
    assign hdr_csum  = hdr_csum_reg;
    assign hdr_valid = hdr_valid_reg;
`endif
endmodule

// File: tb/tb_axis_pkt_buffer.sv
// -----------------------------------------------------------------------------
// tb_axis_pkt_buffer
// Directed bench for axis_pkt_buffer (DATA_W=16, DEPTH=16). Inputs are driven
// 1 time unit after each rising edge and outputs are sampled at that point.
// Header checks are compiled in when AXIS_PKT_BUF_HDR_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axis_pkt_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pkt_count;
    logic [7:0]  drop_count;
    logic        drop;
`ifdef AXIS_PKT_BUF_HDR_EN
    logic [15:0] hdr_src, hdr_dst, hdr_len, hdr_csum;
    logic        hdr_valid;
`endif

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    axis_pkt_buffer_if #(.DATA_W(16)) s_if ();
    axis_pkt_buffer_if #(.DATA_W(16)) m_if ();

    axis_pkt_buffer #(
        .DATA_W (16),
        .DEPTH  (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .s          (s_if),
        .m          (m_if),
        .pkt_count  (pkt_count),
        .drop_count (drop_count),
        .drop       (drop)
`ifdef AXIS_PKT_BUF_HDR_EN
        ,
        .hdr_src    (hdr_src),
        .hdr_dst    (hdr_dst),
        .hdr_len    (hdr_len),
        .hdr_csum   (hdr_csum),
        .hdr_valid  (hdr_valid)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic push(input logic [15:0] d, input logic [1:0] k, input logic l);
        int n = 0;
        s_if.valid = 1'b1;
        s_if.data  = d;
        s_if.keep  = k;
        s_if.last  = l;
        while (!s_if.ready && n < 64) begin
            step();
            n++;
        end
        if (!s_if.ready) check("push_timeout", {31'd0, s_if.ready}, 32'd1);
        step();
        s_if.valid = 1'b0;
        s_if.last  = 1'b0;
    endtask

    task automatic push_run(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            push(base + 16'(i), 2'b11, (i == n - 1));
        end
    endtask

    // Expect one beat on the master side; optionally stall one cycle first.
    task automatic pull(input logic [15:0] d, input logic [1:0] k, input logic l, input logic stall);
        if (stall) begin
            m_if.ready = 1'b0;
            step();
            check("stall_data",    {16'd0, m_if.data}, {16'd0, d});
            check("stall_s_ready", {31'd0, s_if.ready}, 32'd0);
        end
        m_if.ready = 1'b1;
        check("m_valid", {31'd0, m_if.valid}, 32'd1);
        check("m_data",  {16'd0, m_if.data},  {16'd0, d});
        check("m_keep",  {30'd0, m_if.keep},  {30'd0, k});
        check("m_last",  {31'd0, m_if.last},  {31'd0, l});
        check("send_s_ready", {31'd0, s_if.ready}, 32'd0);
        $display("beat out: data=%04h keep=%b last=%b", m_if.data, m_if.keep, m_if.last);
        step();
        m_if.ready = 1'b0;
    endtask

    task automatic pull_run(input logic [15:0] base, input int n, input logic stall);
        for (int i = 0; i < n; i++) begin
            pull(base + 16'(i), 2'b11, (i == n - 1), stall);
        end
    endtask

    initial begin
        reset      = 1'b1;
        s_if.valid = 1'b0;
        s_if.data  = '0;
        s_if.keep  = '0;
        s_if.last  = 1'b0;
        m_if.ready = 1'b0;
        repeat (3) step();
        reset = 1'b0;

        // Reset state
        check("rst_s_ready",    {31'd0, s_if.ready}, 32'd1);
        check("rst_m_valid",    {31'd0, m_if.valid}, 32'd0);
        check("rst_m_last",     {31'd0, m_if.last},  32'd0);
        check("rst_m_data",     {16'd0, m_if.data},  32'd0);
        check("rst_m_keep",     {30'd0, m_if.keep},  32'd0);
        check("rst_pkt_count",  {16'd0, pkt_count},  32'd0);
        check("rst_drop_count", {24'd0, drop_count}, 32'd0);
        check("rst_drop",       {31'd0, drop},       32'd0);
`ifdef AXIS_PKT_BUF_HDR_EN
        check("rst_hdr_valid",  {31'd0, hdr_valid},  32'd0);
        check("rst_hdr_src",    {16'd0, hdr_src},    32'd0);
`endif

        // 4-beat packet, last beat with partial keep
        push(16'h1234, 2'b11, 1'b0);
        push(16'h5678, 2'b11, 1'b0);
        push(16'h0008, 2'b11, 1'b0);
        push(16'hABCD, 2'b01, 1'b1);
        check("p4_latency_valid", {31'd0, m_if.valid}, 32'd1);
`ifdef AXIS_PKT_BUF_HDR_EN
        check("p4_hdr_valid", {31'd0, hdr_valid}, 32'd1);
        check("p4_hdr_src",   {16'd0, hdr_src},  32'h1234);
        check("p4_hdr_dst",   {16'd0, hdr_dst},  32'h5678);
        check("p4_hdr_len",   {16'd0, hdr_len},  32'h0008);
        check("p4_hdr_csum",  {16'd0, hdr_csum}, 32'hABCD);
`endif
        pull(16'h1234, 2'b11, 1'b0, 1'b0);
`ifdef AXIS_PKT_BUF_HDR_EN
        check("p4_hdr_valid_once", {31'd0, hdr_valid}, 32'd0);
`endif
        pull(16'h5678, 2'b11, 1'b0, 1'b0);
        pull(16'h0008, 2'b11, 1'b0, 1'b0);
        pull(16'hABCD, 2'b01, 1'b1, 1'b0);
        check("p4_idle_s_ready", {31'd0, s_if.ready}, 32'd1);
        check("p4_idle_m_valid", {31'd0, m_if.valid}, 32'd0);
        check("p4_pkt_count",    {16'd0, pkt_count},  32'd1);

        // Exactly DEPTH beats: forwarded, not dropped
        push_run(16'h1000, 16);
        check("p16_drop", {31'd0, drop}, 32'd0);
        pull_run(16'h1000, 16, 1'b0);
        check("p16_pkt_count",  {16'd0, pkt_count},  32'd2);
        check("p16_drop_count", {24'd0, drop_count}, 32'd0);

        // DEPTH+1 beats: dropped on the last beat
        push_run(16'h3000, 17);
        check("p17_drop_pulse", {31'd0, drop},       32'd1);
        check("p17_drop_count", {24'd0, drop_count}, 32'd1);
        check("p17_no_m_valid", {31'd0, m_if.valid}, 32'd0);
        step();
        check("p17_drop_once",  {31'd0, drop},       32'd0);
        push(16'hBEEF, 2'b11, 1'b0);
        push(16'hCAFE, 2'b01, 1'b1);
`ifdef AXIS_PKT_BUF_HDR_EN
        check("p2_no_hdr_valid", {31'd0, hdr_valid}, 32'd0);
        check("p2_hdr_kept",     {16'd0, hdr_src},   32'h1000);
`endif
        pull(16'hBEEF, 2'b11, 1'b0, 1'b0);
        pull(16'hCAFE, 2'b01, 1'b1, 1'b0);
        check("p2_pkt_count", {16'd0, pkt_count}, 32'd3);

        // Stalled replay; an inbound beat waits during SEND and is not lost
        push_run(16'h2000, 5);
        s_if.valid = 1'b1;
        s_if.data  = 16'h0077;
        s_if.keep  = 2'b01;
        s_if.last  = 1'b1;
        pull_run(16'h2000, 5, 1'b1);
        check("held_s_ready", {31'd0, s_if.ready}, 32'd1);
        step();
        s_if.valid = 1'b0;
        s_if.last  = 1'b0;
        pull(16'h0077, 2'b01, 1'b1, 1'b0);
        check("held_pkt_count", {16'd0, pkt_count}, 32'd5);
`ifdef AXIS_PKT_BUF_HDR_EN
        check("held_hdr_src", {16'd0, hdr_src}, 32'h2000);
`endif

        // Reset on beat 3 of a 6-beat packet
        push(16'h5000, 2'b11, 1'b0);
        push(16'h5001, 2'b11, 1'b0);
        s_if.valid = 1'b1;
        s_if.data  = 16'h5002;
        s_if.keep  = 2'b11;
        reset      = 1'b1;
        step();
        reset      = 1'b0;
        s_if.valid = 1'b0;
        check("mid_rst_pkt_count",  {16'd0, pkt_count},  32'd0);
        check("mid_rst_drop_count", {24'd0, drop_count}, 32'd0);
        check("mid_rst_drop",       {31'd0, drop},       32'd0);
        check("mid_rst_m_valid",    {31'd0, m_if.valid}, 32'd0);
        push(16'h00FF, 2'b01, 1'b1);
        pull(16'h00FF, 2'b01, 1'b1, 1'b0);
        check("mid_rst_pkt_after", {16'd0, pkt_count}, 32'd1);

        // 300 oversized packets through the DROP state: counter saturates
        for (int i = 0; i < 300; i++) begin
            push_run(16'h4000, 20);
            if (i == 253) check("sat_254", {24'd0, drop_count}, 32'd254);
        end
        check("sat_255",        {24'd0, drop_count}, 32'd255);
        check("sat_no_m_valid", {31'd0, m_if.valid}, 32'd0);
        check("sat_pkt_count",  {16'd0, pkt_count},  32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
